// File: rtl/memory.sv
// Single-port word memory: synchronous read and write, write-first data_out,
// synchronous clear of all storage, out-of-range accesses read as zero.
module memory #(
  parameter int SIZE       = 4096,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  // One extra bit so SIZE == 2**ADDR_WIDTH is representable as the limit.
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(SIZE);

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  assign in_range = ({1'b0, addr} < LIMIT);
  assign idx      = addr[IDX_W-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: clearing every word forces flip-flop storage instead of a RAM
      // macro; it is required because software relies on a zeroed store.
      for (int i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
      data_out <= '0;
    end else if (!in_range) begin
      data_out <= '0;
    end else if (write_enable) begin
      mem[idx] <= data_in;
      data_out <= data_in;
    end else begin
      data_out <= mem[idx];
    end
  end

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: two instances (full depth and SIZE=1337),
// expected data from a simple array model, checked by a separate monitor.
module tb_memory;

  localparam int SMALL = 1337;

  typedef struct {
    logic [11:0] val;
    logic [11:0] a;
    bit          we;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [11:0] addr_b, din_b, data_b;
  logic [11:0] addr_s, din_s, data_s;
  logic        we_b, we_s;
  bit          act_b, act_s;

  exp_t q_b[$];
  exp_t q_s[$];
  logic [11:0] mb [4096];
  logic [11:0] ms [SMALL];

  int total = 0;
  int bad   = 0;

  memory #(.SIZE(4096), .DATA_WIDTH(12), .ADDR_WIDTH(12)) u_big (
    .clk(clk), .rst(rst), .addr(addr_b), .write_enable(we_b),
    .data_in(din_b), .data_out(data_b)
  );

  memory #(.SIZE(SMALL), .DATA_WIDTH(12), .ADDR_WIDTH(12)) u_small (
    .clk(clk), .rst(rst), .addr(addr_s), .write_enable(we_s),
    .data_in(din_s), .data_out(data_s)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every edge on which the bench issued an access must produce the
  // next queued response on data_out just after that edge.
  initial begin
    bit ab, as;
    exp_t e;
    forever begin
      @(posedge clk);
      ab = act_b;
      as = act_s;
      #1;
      if (ab) begin
        if (q_b.size() == 0) check("big_sb_empty", 1, 0);
        else begin
          e = q_b.pop_front();
          check($sformatf("big %s a=%0h", e.we ? "wr" : "rd", e.a), int'(data_b), int'(e.val));
        end
      end
      if (as) begin
        if (q_s.size() == 0) check("small_sb_empty", 1, 0);
        else begin
          e = q_s.pop_front();
          check($sformatf("small %s a=%0h", e.we ? "wr" : "rd", e.a), int'(data_s), int'(e.val));
        end
      end
    end
  end

  // Issue one access to the chosen instance (s=1: small) on the next edge.
  task automatic access(input bit s, input bit we, input int a, input int d);
    exp_t e;
    @(negedge clk);
    e.a  = 12'(a);
    e.we = we;
    if (!s) begin
      addr_b = 12'(a); we_b = we; din_b = 12'(d);
      act_b = 1; act_s = 0; we_s = 0;
      if (we) mb[a] = 12'(d);
      e.val = mb[a];
      q_b.push_back(e);
    end else begin
      addr_s = 12'(a); we_s = we; din_s = 12'(d);
      act_s = 1; act_b = 0; we_b = 0;
      if (a >= SMALL) e.val = 12'h000;
      else begin
        if (we) ms[a] = 12'(d);
        e.val = ms[a];
      end
      q_s.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    act_b = 0; act_s = 0; we_b = 0; we_s = 0;
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst = 1; we_b = 1; we_s = 1;   // write_enable must be ignored under reset
    din_b = 12'hFFF; din_s = 12'hFFF;
    act_b = 1; act_s = 1;
    foreach (mb[i]) mb[i] = 12'h000;
    foreach (ms[i]) ms[i] = 12'h000;
    e.val = 12'h000; e.a = addr_b; e.we = 0;
    q_b.push_back(e);
    e.a = addr_s;
    q_s.push_back(e);
    @(negedge clk);
    rst = 0; act_b = 0; act_s = 0; we_b = 0; we_s = 0;
  endtask

  initial begin
    rst = 0; addr_b = 0; addr_s = 0; din_b = 0; din_s = 0;
    we_b = 0; we_s = 0; act_b = 0; act_s = 0;

    do_reset();

    // Reset clears a previously written word.
    access(0, 1, 5, 12'hABC);
    access(1, 1, 5, 12'hABC);
    do_reset();
    access(0, 0, 5, 0);
    access(1, 0, 5, 0);

    // Latency, hold, and addr change between edges.
    access(0, 1, 10, 12'h123);
    access(0, 1, 11, 12'h456);
    access(0, 0, 10, 0);
    access(0, 0, 11, 0);
    idle();
    repeat (3) @(posedge clk);
    #1 check("big hold", int'(data_b), int'(mb[11]));
    @(negedge clk);
    addr_b = 12'd10;
    #1 check("big addr change no edge", int'(data_b), 32'h456);

    // Overwrite and untouched neighbours.
    access(0, 1, 100, 12'h0F0);
    access(0, 1, 100, 12'hF0F);
    access(0, 0, 100, 0);
    access(0, 0, 99, 0);
    access(0, 0, 101, 0);

    // Out-of-range behaviour at SIZE=1337.
    access(1, 1, 1336, 12'h777);
    access(1, 1, 1337, 12'h555);
    access(1, 0, 1336, 0);
    access(1, 0, 1337, 0);
    access(1, 1, 4095, 12'h321);
    access(1, 0, 4095, 0);
    access(1, 0, 1336, 0);

    // Boundary data on both ends of both depths.
    access(0, 1, 0, 12'hFFF);
    access(0, 1, 4095, 12'h000);
    access(0, 0, 0, 0);
    access(0, 0, 4095, 0);
    access(1, 1, 0, 12'hFFF);
    access(1, 1, SMALL - 1, 12'h000);
    access(1, 0, 0, 0);
    access(1, 0, SMALL - 1, 0);

    // Full-rate write/read sweep.
    for (int i = 0; i < 4095; i++) begin
      access(0, 1, i, i);
      access(0, 0, i, 0);
    end

    // Random mix across both instances, biased toward the small boundary.
    for (int k = 0; k < 1500; k++) begin
      bit s, we;
      int a;
      s  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if (s && $urandom_range(0, 1) == 1) a = $urandom_range(SMALL - 40, SMALL + 40);
      else a = $urandom_range(0, 4095);
      access(s, we, a, $urandom_range(0, 4095));
    end

    idle();
    repeat (3) @(posedge clk);
    #2 check("scoreboard drained", q_b.size() + q_s.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Single-port, synchronous-read/synchronous-write word memory for the CPU: 12-bit address, 12-bit data.
- Serves as the unified program/data store.
- One access per cycle: a write when write_enable is high, otherwise a read.
- Depth is parameterised; addresses beyond the implemented depth are handled deterministically.

Parameters:
- SIZE, 4096, number of implemented words (1..4096); valid addresses are 0..SIZE-1.
- DATA_WIDTH, 12, word width in bits.
- ADDR_WIDTH, 12, address width in bits; requires SIZE <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_WIDTH  word address for the current access.
- write_enable  input  1  1 = write data_in to addr this cycle; 0 = read addr.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- All sequential logic triggers on posedge clk only. No combinational path from inputs to data_out.
- Reset (rst=1 at a rising edge):
  - data_out <= 0.
  - Every storage word <= 0.
  - Takes effect within that single edge; write_enable is ignored while rst=1.
  - First valid access is possible on the cycle after rst deasserts.
- Write (rst=0, write_enable=1, addr < SIZE):
  - mem[addr] <= data_in at the rising edge.
  - data_out <= data_in on the same edge (write-first). The new value is visible on data_out immediately after that edge.
- Read (rst=0, write_enable=0, addr < SIZE):
  - data_out <= mem[addr] at the rising edge.
  - Latency is 1 cycle: addr presented before edge N gives data on data_out after edge N.
- Out-of-range address (addr >= SIZE):
  - Write is discarded; no storage word changes.
  - data_out <= 0 for both read and write.
  - No aliasing or wrap-around.
- data_out holds its value between edges. Changing addr mid-cycle does not affect data_out until the next edge.
- Back-to-back accesses, including alternating write/read every cycle, are supported at full rate with no bubbles.
- Write followed next cycle by a read of the same address returns the newly written value.
- No partial writes; the whole word is replaced.
- X on write_enable is not defined behaviour; the bench drives it to 0 or 1 at all times.

Test Plan:
- Reset: write 12'hABC to addr 5, then assert rst for 1 cycle, then read addr 5 -> data_out = 0 after reset edge and after read edge.
- Write/read sweep, SIZE=4096: for i = 0..4094, write value i at addr i, next cycle read addr i -> data_out = i one cycle after each read; also equals i right after each write edge.
- Latency/hold: write 12'h123 to addr 10 and 12'h456 to addr 11; read 10 then 11 on consecutive cycles -> data_out = 12'h123 after first edge, 12'h456 after second; value holds while clock idles with no addr change.
- Overwrite: write 12'h0F0 then 12'hF0F to addr 100, then read 100 -> 12'hF0F; neighbouring addrs 99/101 still read 0 after reset.
- Out of range, SIZE=1337: write 12'h777 to addr 1336, then 12'h555 to addr 1337, then read 1336 and 1337 -> 12'h777 and 0 respectively; data_out = 0 on the 1337 write edge.
- Boundary data: write 12'hFFF to addr 0 and 12'h000 to addr SIZE-1, then read both -> 12'hFFF and 12'h000; no bleed between ends.
